score_meter: RTL



---
 rtl/score_meter_if.sv | 27 ++
 rtl/score_meter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/score_meter_if.sv
// Pixel-scan bus between the VGA timing/score sources and score_meter.
// The master drives the frame strobe, scan position and packed scores;
// the slave returns the per-pixel layer flags for the colour mapper.
interface score_meter_if #(
  parameter int NUM_BARS = 2,
  parameter int SCORE_W  = 16
) ();
  localparam int IDX_W = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;

  logic                        frame_clk;
  logic [9:0]                  DrawX;
  logic [9:0]                  DrawY;
  logic [NUM_BARS*SCORE_W-1:0] score;
  logic                        is_bar;
  logic                        is_peak;
  logic [IDX_W-1:0]            bar_idx;

  modport master (
    output frame_clk, DrawX, DrawY, score,
    input  is_bar, is_peak, bar_idx
  );

  modport slave (
    input  frame_clk, DrawX, DrawY, score,
    output is_bar, is_peak, bar_idx
  );
endinterface

// File: rtl/score_meter.sv
// score_meter: NUM_BARS animated vertical score meters for the VGA pixel path.
// Each meter eases toward score >> SCALE_SHIFT (clamped to BAR_H) by at most
// STEP pixels per frame. Per-pixel flags are registered (1-cycle latency).
// Optional peak-hold marker is compiled in when SCORE_METER_PEAK_EN is defined.
module score_meter #(
  parameter int NUM_BARS    = 2,
  parameter int SCORE_W     = 16,
  parameter int SCALE_SHIFT = 8,
  parameter int BAR_X0      = 480,
  parameter int BAR_W       = 20,
  parameter int BAR_GAP     = 8,
  parameter int BAR_TOP     = 0,
  parameter int BAR_H       = 480,
  parameter int STEP        = 4,
  parameter int PEAK_HOLD   = 30
) (
  input logic          Clk,
  input logic          Reset,
  score_meter_if.slave bus
);

  localparam int IDX_W  = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
  localparam int H_W    = $clog2(BAR_H + 1);
  localparam int CMP_W  = (SCORE_W > 32) ? SCORE_W : 32;
  localparam int BAR_BOT = BAR_TOP + BAR_H;  // first row below the meter area

  logic             frame_d;
  logic             fe;
  logic [H_W-1:0]   cur_h [NUM_BARS];
  logic [H_W-1:0]   tgt   [NUM_BARS];
  logic [H_W-1:0]   nxt_h [NUM_BARS];

  // Frame strobe edge detector; frame_d starts high so a strobe already
  // high when Reset drops is not mistaken for a new frame.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (Reset) frame_d <= 1'b1;
    else       frame_d <= bus.frame_clk;
  end

  assign fe = bus.frame_clk & ~frame_d;

  // Per-bar target (shift at full score width, then clamp) and the next
  // animated height, limited to STEP toward the target without overshoot.
  always_comb begin
    // NOTE: every array element gets a value before any branch, so no latch
    // can be inferred for paths that leave a height unchanged.
    for (int k = 0; k < NUM_BARS; k++) begin
      logic [CMP_W-1:0] raw;
      raw    = CMP_W'(bus.score[k*SCORE_W +: SCORE_W] >> SCALE_SHIFT);
      tgt[k] = (raw > CMP_W'(BAR_H)) ? H_W'(BAR_H) : H_W'(raw);
      nxt_h[k] = cur_h[k];
      if (cur_h[k] < tgt[k]) begin
        if ((tgt[k] - cur_h[k]) > H_W'(STEP)) nxt_h[k] = cur_h[k] + H_W'(STEP);
        else                                  nxt_h[k] = tgt[k];
      end else if (cur_h[k] > tgt[k]) begin
        if ((cur_h[k] - tgt[k]) > H_W'(STEP)) nxt_h[k] = cur_h[k] - H_W'(STEP);
        else                                  nxt_h[k] = tgt[k];
      end
    end
  end

  // Height registers advance once per detected frame edge; Reset wins.
  always_ff @(posedge Clk) begin
    // NOTE: these arrays are a handful of flops, not a RAM, so clearing
    // them in reset is cheap and required for the regrow-from-0 behaviour.
    if (Reset) begin
      for (int k = 0; k < NUM_BARS; k++) cur_h[k] <= '0;
    end else if (fe) begin
      for (int k = 0; k < NUM_BARS; k++) cur_h[k] <= nxt_h[k];
    end
  end

`ifdef SCORE_METER_PEAK_EN
  localparam int HC_W = $clog2(PEAK_HOLD + 1);

  logic [H_W-1:0]  peak_h   [NUM_BARS];
  logic [HC_W-1:0] hold_cnt [NUM_BARS];

  // Peak tracker: latch new highs, hold for PEAK_HOLD frames, then sink
  // one row per frame until it meets the bar again.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < NUM_BARS; k++) begin
        peak_h[k]   <= '0;
        hold_cnt[k] <= '0;
      end
    end else if (fe) begin
      for (int k = 0; k < NUM_BARS; k++) begin
        if (nxt_h[k] >= peak_h[k]) begin
          peak_h[k]   <= nxt_h[k];
          hold_cnt[k] <= HC_W'(PEAK_HOLD);
        end else if (hold_cnt[k] != '0) begin
          hold_cnt[k] <= hold_cnt[k] - 1'b1;
        end else if (peak_h[k] > nxt_h[k]) begin
          peak_h[k]   <= peak_h[k] - 1'b1;
        end
      end
    end
  end
`endif

  int               px;
  int               py;
  logic             hit_bar;
  logic             hit_peak;
  logic [IDX_W-1:0] hit_idx;

  // Scan-position comparators: column match, fill span and peak row per bar.
  always_comb begin
    px       = int'(bus.DrawX);
    py       = int'(bus.DrawY);
    hit_bar  = 1'b0;
    hit_peak = 1'b0;
    hit_idx  = '0;
    for (int k = 0; k < NUM_BARS; k++) begin
      if (px >= BAR_X0 + k*(BAR_W+BAR_GAP) &&
          px <  BAR_X0 + k*(BAR_W+BAR_GAP) + BAR_W) begin
        hit_idx = IDX_W'(k);
        if (py >= BAR_BOT - int'(cur_h[k]) && py < BAR_BOT) hit_bar = 1'b1;
`ifdef SCORE_METER_PEAK_EN
        if (peak_h[k] != '0 && py == BAR_BOT - int'(peak_h[k])) hit_peak = 1'b1;
`endif
      end
    end
  end

  // Output register: flags describe the pixel presented one cycle earlier.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.is_bar  <= 1'b0;
      bus.bar_idx <= '0;
    end else begin
      bus.is_bar  <= hit_bar;
      bus.bar_idx <= hit_idx;
    end
  end

`ifdef SCORE_METER_PEAK_EN
  // Peak flag register, aligned with is_bar.
  always_ff @(posedge Clk) begin
    if (Reset) bus.is_peak <= 1'b0;
    else       bus.is_peak <= hit_peak;
  end
`else
  assign bus.is_peak = 1'b0;
`endif

endmodule
